// File: rtl/cba_pkg.sv
// Shared constants and types for the carry-bypass adder.
// Optional feature: define CBA_OVERFLOW_EN to add the registered signed-overflow output.
package cba_pkg;

    localparam int unsigned CBA_WIDTH   = 32;
    localparam int unsigned CBA_BLOCK   = 4;
    localparam int unsigned CBA_NBLOCKS = CBA_WIDTH / CBA_BLOCK;

    // Operand / sum word at the default width.
    typedef logic [CBA_WIDTH-1:0] cba_word_t;

endpackage : cba_pkg

// File: rtl/cba_block.sv
// One carry-bypass block: BLOCK-bit ripple adder whose carry-out is taken
// straight from the block carry-in whenever every bit propagates.
// Ports:
//   a, b    BLOCK-bit operand slices
//   cin     block carry-in
//   sum_c   combinational sum bits of this block
//   cout_c  combinational block carry-out (bypass mux output)
module cba_block
    import cba_pkg::*;
#(
    parameter int unsigned BLOCK = CBA_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum_c,
    output logic             cout_c
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    logic             blk_prop;

    // Ripple carry, sum bits, group propagate and bypass mux.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(BLOCK); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum_c    = p ^ c[BLOCK-1:0];
        blk_prop = &p;
        // When the whole block propagates, the carry skips the ripple path.
        cout_c   = blk_prop ? cin : c[BLOCK];
    end

endmodule : cba_block

// File: rtl/carry_bypass_adder.sv
// Registered 32-bit carry-bypass (carry-skip) adder: sum = a+b+cin mod 2^WIDTH,
// cout = unsigned carry out, one cycle of latency.
// Optional feature: `define CBA_OVERFLOW_EN adds the registered signed overflow port ovf.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears sum/cout/ovf
//   a, b   WIDTH-bit operands
//   cin    carry into bit 0
//   sum    registered sum
//   cout   registered carry out of bit WIDTH-1
//   ovf    registered signed overflow (CBA_OVERFLOW_EN only)
module carry_bypass_adder
    import cba_pkg::*;
#(
    parameter int unsigned WIDTH = CBA_WIDTH,
    parameter int unsigned BLOCK = CBA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CBA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    // WIDTH must be a multiple of BLOCK.
    localparam int unsigned NBLK = WIDTH / BLOCK;

    logic [WIDTH-1:0] sum_c;
    logic             cout_c;

    // Bypass chain, LSB block first; each block's carry-in is the previous carry-out.
    for (genvar k = 0; k < int'(NBLK); k++) begin : g_blk
        logic ci;
        logic co;

        if (k == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_blk[k-1].co;
        end

        cba_block #(
            .BLOCK (BLOCK)
        ) u_block (
            .a      (a[k*BLOCK +: BLOCK]),
            .b      (b[k*BLOCK +: BLOCK]),
            .cin    (ci),
            .sum_c  (sum_c[k*BLOCK +: BLOCK]),
            .cout_c (co)
        );
    end

    assign cout_c = g_blk[NBLK-1].co;

`ifdef CBA_OVERFLOW_EN
    logic ovf_c;

    // Signed overflow: like-signed operands producing a sum of the other sign.
    assign ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
`endif

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
`ifdef CBA_OVERFLOW_EN
            ovf  <= 1'b0;
`endif
        end else begin
            sum  <= sum_c;
            cout <= cout_c;
`ifdef CBA_OVERFLOW_EN
            ovf  <= ovf_c;
`endif
        end
    end

endmodule : carry_bypass_adder

// File: tb/tb_carry_bypass_adder.sv
// Scoreboard bench for carry_bypass_adder: the driver pushes the reference result
// for every vector, the monitor pops and compares one edge later.
module tb_carry_bypass_adder;
    import cba_pkg::*;

    localparam int unsigned W = CBA_WIDTH;

    typedef struct {
        cba_word_t s;
        logic      co;
        logic      ov;
    } exp_t;

    logic      clk;
    logic      rst_n;
    cba_word_t a;
    cba_word_t b;
    logic      cin;
    cba_word_t sum;
    logic      cout;
`ifdef CBA_OVERFLOW_EN
    logic      ovf;
`endif

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb[$];

    carry_bypass_adder #(
        .WIDTH (W),
        .BLOCK (CBA_BLOCK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
`ifdef CBA_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide arithmetic, overflow as a signed range check.
    function automatic exp_t model(input cba_word_t va, input cba_word_t vb, input logic vc);
        exp_t        e;
        logic [W:0]  full;
        longint      sv;
        longint      max_pos;
        longint      min_neg;
        full    = (W+1)'(va) + (W+1)'(vb) + (W+1)'(vc);
        sv      = longint'($signed(va)) + longint'($signed(vb)) + longint'(vc);
        max_pos = 64'sd2147483647;
        min_neg = -64'sd2147483648;
        e.s  = full[W-1:0];
        e.co = full[W];
        e.ov = (sv > max_pos) || (sv < min_neg);
        return e;
    endfunction

    task automatic drive(input cba_word_t va, input cba_word_t vb, input logic vc);
        a   = va;
        b   = vb;
        cin = vc;
        sb.push_back(model(va, vb, vc));
    endtask

    task automatic apply(input cba_word_t va, input cba_word_t vb, input logic vc);
        @(negedge clk);
        drive(va, vb, vc);
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (sum !== '0 || cout !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: sum=%h cout=%b, required sum=0 cout=0", name, sum, cout);
        end
`ifdef CBA_OVERFLOW_EN
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: ovf=%b, required 0", name, ovf);
        end
`endif
    endtask

    // Monitor: result of the vector captured at this edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (sum !== e.s || cout !== e.co) begin
                miscompares++;
                $display("FAIL result: sum=%h cout=%b, required sum=%h cout=%b",
                         sum, cout, e.s, e.co);
            end
`ifdef CBA_OVERFLOW_EN
            vectors++;
            if (ovf !== e.ov) begin
                miscompares++;
                $display("FAIL ovf: ovf=%b, required %b (sum=%h)", ovf, e.ov, e.s);
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cba_word_t ra;
        cba_word_t rb;
        rst_n = 1'b1;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("reset_initial");

        // Release between edges; the next edge captures the first vector.
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        apply(32'h0000_0005, 32'hFFFF_FFFD, 1'b0);
        apply(32'hFFFF_FFF1, 32'h0000_0014, 1'b0);
        apply(32'h0000_000C, 32'hFFFF_FFF8, 1'b1);
        apply(32'hFFFF_FFFC, 32'hFFFF_FFFA, 1'b0);
        apply(32'h0000_0000, 32'h0000_0000, 1'b1);
        apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        apply(32'h5555_5555, 32'hAAAA_AAAA, 1'b0);
        apply(32'h0000_0007, 32'h0000_0003, 1'b0);

        // Mid-stream asynchronous reset while sum is non-zero.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("reset_async");
        sb.delete();
        @(negedge clk);
        a   = 32'h1234_5678;
        b   = 32'h0FED_CBA9;
        cin = 1'b1;
        @(posedge clk);
        #1 check_zero("reset_held_edge");

        // Release; next edge yields the result for the inputs now present.
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h1234_5678, 32'h0FED_CBA9, 1'b1);

        // Random vectors, biased toward long propagate runs.
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ~ra;
                1:       rb = ~ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = $urandom;
            endcase
            apply(ra, rb, 1'($urandom_range(0, 1)));
        end

        // Drain and confirm every expected result was consumed.
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_carry_bypass_adder
